diaosi_mem_arbiter: RTL and testbench

//   Shares the single RAM port between pipeline instruction fetch (I) and data memory (D).

---
 rtl/diaosi_types_pkg.sv | 12 +
 rtl/diaosi_sat_counter.sv | 29 ++
 rtl/diaosi_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_diaosi_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/diaosi_types_pkg.sv
// rtl/diaosi_types_pkg.sv - shared enums for the diaosi memory arbiter
package diaosi_types_pkg;

  typedef enum logic [1:0] {IDLE_DIAOSI, IGRANT_DIAOSI, DGRANT_DIAOSI} Arb_t;
  typedef enum logic [1:0] {FREE_DS, BUSY_DS, ACCESS_DS, ERROR_DS} Ramstate_t;

  // ACCESS and ERROR both end a transaction; only ACCESS is clean.
  function automatic logic ram_finished(Ramstate_t s);
    return (s == ACCESS_DS) || (s == ERROR_DS);
  endfunction

endpackage

// File: rtl/diaosi_sat_counter.sv
// rtl/diaosi_sat_counter.sv - saturating up counter with sync clear and saturation flag
module diaosi_sat_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_sat = (r_count == MAX_V);

endmodule

// File: rtl/diaosi_mem_arbiter.sv
// rtl/diaosi_mem_arbiter.sv - shares one RAM port between instruction fetch and data memory
module diaosi_mem_arbiter
  import diaosi_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              mem_err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int TW = $clog2(TIMEOUT);

  Arb_t      r_state;
  Arb_t      w_next;
  Ramstate_t w_rs;
  logic      r_mem_err;
  logic      w_dreq, w_fin, w_idone, w_ddone, w_set_err;
  logic      w_streak_sat, w_tmo_sat, w_hold;

  assign w_rs   = Ramstate_t'(ramstate);
  assign w_dreq = dREN | dWEN;
  // The timeout counter saturates exactly on the last allowed grant cycle.
  assign w_fin  = ram_finished(w_rs) | w_tmo_sat;
  assign w_hold = (r_state != IDLE_DIAOSI) && (w_next == r_state);

  always_comb begin
    w_next    = r_state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    w_idone   = 1'b0;
    w_ddone   = 1'b0;
    w_set_err = 1'b0;
    case (r_state)
      IDLE_DIAOSI: begin
        if (w_dreq && !w_streak_sat) w_next = DGRANT_DIAOSI;
        else if (iREN)               w_next = IGRANT_DIAOSI;
      end
      IGRANT_DIAOSI: begin
        if (!iREN) begin
          w_next = IDLE_DIAOSI;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (w_fin) begin
            iwait     = 1'b0;
            iload     = ramload;
            w_idone   = 1'b1;
            w_set_err = (w_rs != ACCESS_DS);
            w_next    = IDLE_DIAOSI;
          end
        end
      end
      DGRANT_DIAOSI: begin
        if (!w_dreq) begin
          w_next = IDLE_DIAOSI;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (w_fin) begin
            dwait     = 1'b0;
            dload     = ramload;
            w_ddone   = 1'b1;
            w_set_err = (w_rs != ACCESS_DS);
            w_next    = IDLE_DIAOSI;
          end
        end
      end
      default: w_next = IDLE_DIAOSI;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE_DIAOSI;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_err) r_mem_err <= 1'b1;
    end
  end

  assign mem_err = r_mem_err;

  diaosi_sat_counter #(.WIDTH(SW), .MAX(MAX_DSTREAK)) u_streak (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_inc   (w_ddone & iREN),
    .i_clr   (w_idone | (w_ddone & ~iREN)),
    .o_sat   (w_streak_sat)
  );

  diaosi_sat_counter #(.WIDTH(TW), .MAX(TIMEOUT - 1)) u_tmo (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_inc   (w_hold),
    .i_clr   (r_state == IDLE_DIAOSI),
    .o_sat   (w_tmo_sat)
  );

endmodule

// File: tb/tb_diaosi_mem_arbiter.sv
// tb/tb_diaosi_mem_arbiter.sv - self-checking bench for diaosi_mem_arbiter
module tb_diaosi_mem_arbiter;
  import diaosi_types_pkg::*;

  localparam int MAXD = 4;
  localparam int TMO  = 255;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int errors = 0;
  int checks = 0;

  int m_owner, m_age, m_streak, n_owner, n_age, n_streak;
  bit m_err, n_err;
  logic        e_iwait, e_dwait, e_ramREN, e_ramWEN;
  logic [31:0] e_ramaddr, e_ramstore, e_iload, e_dload;

  always #5 CLK = ~CLK;

  diaosi_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .mem_err(mem_err)
  );

  // Owner: 0 nobody, 1 fetch, 2 data; age counts cycles spent owning the RAM.
  task automatic model_eval();
    bit dreq, fin, bad;
    dreq = dREN || dWEN;
    fin  = (ramstate == ACCESS_DS) || (ramstate == ERROR_DS) || (m_age == TMO - 1);
    bad  = (ramstate != ACCESS_DS);
    e_iwait = 1; e_dwait = 1; e_ramREN = 0; e_ramWEN = 0;
    e_ramaddr = 0; e_ramstore = 0; e_iload = 0; e_dload = 0;
    n_owner = m_owner; n_age = m_age; n_streak = m_streak; n_err = m_err;
    if (m_owner == 0) begin
      n_age = 0;
      if (dreq && m_streak < MAXD) n_owner = 2;
      else if (iREN)               n_owner = 1;
    end else if (m_owner == 1) begin
      if (!iREN) n_owner = 0;
      else begin
        e_ramREN = 1; e_ramaddr = iaddr;
        if (fin) begin
          e_iwait = 0; e_iload = ramload; n_owner = 0; n_streak = 0;
          if (bad) n_err = 1;
        end else n_age = m_age + 1;
      end
    end else begin
      if (!dreq) n_owner = 0;
      else begin
        e_ramaddr = daddr; e_ramstore = dstore;
        e_ramWEN = dWEN; e_ramREN = dREN && !dWEN;
        if (fin) begin
          e_dwait = 0; e_dload = ramload; n_owner = 0;
          n_streak = iREN ? ((m_streak + 1 > MAXD) ? MAXD : m_streak + 1) : 0;
          if (bad) n_err = 1;
        end else n_age = m_age + 1;
      end
    end
  endtask

  task automatic tick();
    model_eval();
    m_owner = n_owner; m_age = n_age; m_streak = n_streak; m_err = n_err;
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    m_owner = 0; m_age = 0; m_streak = 0; m_err = 0;
  endtask

  task automatic do_reset();
    nRST = 0;
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE_DS;
    model_clear();
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  task automatic test_reset();
    do_reset();
    dREN = 1; daddr = 32'h10; ramstate = ERROR_DS;
    @(negedge CLK); tick();
    @(negedge CLK);
    checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL reset_pre_err: dwait got %b expected 0", dwait); end
    tick(); ramstate = BUSY_DS;
    @(negedge CLK);
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL reset_pre_sticky: mem_err got %b expected 1", mem_err); end
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1) begin errors++; $display("FAIL reset_pre_grant: ramREN got %b expected 1", ramREN); end
    #2 nRST = 0;
    #1;
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin errors++; $display("FAIL reset_ram: REN/WEN got %b%b expected 00", ramREN, ramWEN); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL reset_wait: i/d got %b%b expected 11", iwait, dwait); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL reset_bus: addr %h store %h expected 0", ramaddr, ramstore); end
    model_clear();
    @(posedge CLK); #1; nRST = 1;
  endtask

  task automatic test_lone_fetch();
    do_reset();
    iREN = 1; iaddr = 32'h40; ramstate = BUSY_DS; ramload = 32'h2108000A;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL fetch_c0: ramREN %b iwait %b expected 0 1", ramREN, iwait); end
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40 || iwait !== 1'b1) begin errors++; $display("FAIL fetch_c1: ramREN %b addr %h iwait %b expected 1 40 1", ramREN, ramaddr, iwait); end
    tick(); ramstate = ACCESS_DS;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || iwait !== 1'b0 || iload !== 32'h2108000A) begin errors++; $display("FAIL fetch_c2: ramREN %b iwait %b iload %h expected 1 0 2108000a", ramREN, iwait, iload); end
    tick(); iREN = 0; ramstate = FREE_DS;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL fetch_c3: ramREN %b iwait %b expected 0 1", ramREN, iwait); end
    tick();
  endtask

  task automatic test_contention();
    int seq[$];
    do_reset();
    iREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'hDEAD; iaddr = 32'h44; ramstate = ACCESS_DS;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!dwait) begin
        seq.push_back(1);
        checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h80 || ramstore !== 32'hDEAD) begin
          errors++; $display("FAIL contention_dbus: cycle %0d WEN %b REN %b addr %h store %h", c, ramWEN, ramREN, ramaddr, ramstore);
        end
      end
      if (!iwait) begin
        seq.push_back(2);
        checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin
          errors++; $display("FAIL contention_ibus: cycle %0d REN %b addr %h expected 1 44", c, ramREN, ramaddr);
        end
      end
      tick();
    end
    checks++; if (seq.size() != 10) begin errors++; $display("FAIL contention_count: got %0d completions expected 10", seq.size()); end
    for (int k = 0; k < seq.size() && k < 10; k++) begin
      checks++; if (seq[k] != ((k % 5 == 4) ? 2 : 1)) begin errors++; $display("FAIL contention_order: slot %0d got %0d expected %0d", k, seq[k], (k % 5 == 4) ? 2 : 1); end
    end
    iREN = 0; dWEN = 0;
    tick();
  endtask

  task automatic test_simultaneous();
    int d_first = -1, i_first = -1;
    do_reset();
    iREN = 1; dREN = 1; iaddr = 32'h48; daddr = 32'h84; ramstate = ACCESS_DS;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (!dwait && d_first < 0) d_first = c;
      if (!iwait && i_first < 0) i_first = c;
      tick();
      if (d_first >= 0) dREN = 0;
    end
    checks++; if (d_first != 1) begin errors++; $display("FAIL simul_d: done cycle got %0d expected 1", d_first); end
    checks++; if (i_first != 3) begin errors++; $display("FAIL simul_i: done cycle got %0d expected 3", i_first); end
    iREN = 0;
    tick();
  endtask

  task automatic test_timeout_error();
    int first = -1;
    bit stop = 0;
    do_reset();
    iREN = 1; iaddr = 32'h100; ramstate = BUSY_DS;
    for (int c = 0; c < 300 && !stop; c++) begin
      @(negedge CLK);
      if (c == 254) begin
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL tmo_early_err: mem_err got %b expected 0", mem_err); end
      end
      if (first < 0 && !iwait) first = c;
      else if (first >= 0) begin
        checks++; if (iwait !== 1'b1 || mem_err !== 1'b1) begin errors++; $display("FAIL tmo_after: iwait %b mem_err %b expected 1 1", iwait, mem_err); end
        stop = 1;
      end
      tick();
    end
    checks++; if (first != 255) begin errors++; $display("FAIL tmo_cycle: done cycle got %0d expected 255", first); end
    iREN = 0; ramstate = ACCESS_DS;
    repeat (5) tick();
    @(negedge CLK);
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: mem_err got %b expected 1", mem_err); end
    do_reset();
    dWEN = 1; daddr = 32'h88; ramstate = ERROR_DS; ramload = 32'h5A5A;
    @(negedge CLK);
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL err_clear: mem_err got %b expected 0", mem_err); end
    tick();
    @(negedge CLK);
    checks++; if (dwait !== 1'b0 || dload !== 32'h5A5A) begin errors++; $display("FAIL err_done: dwait %b dload %h expected 0 5a5a", dwait, dload); end
    tick(); dWEN = 0;
    @(negedge CLK);
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_set: mem_err got %b expected 1", mem_err); end
    tick();
  endtask

  task automatic test_withdrawal();
    do_reset();
    dREN = 1; iREN = 1; iaddr = 32'h44; daddr = 32'h90; ramstate = BUSY_DS;
    @(negedge CLK); tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h90) begin errors++; $display("FAIL wd_grant: REN %b addr %h expected 1 90", ramREN, ramaddr); end
    tick(); dREN = 0;
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL wd_abort: REN %b dwait %b expected 0 1", ramREN, dwait); end
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL wd_idle: REN %b iwait %b expected 0 1", ramREN, iwait); end
    tick();
    @(negedge CLK);
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44 || iwait !== 1'b1) begin errors++; $display("FAIL wd_igrant: REN %b addr %h iwait %b expected 1 44 1", ramREN, ramaddr, iwait); end
    iREN = 0;
    tick();
  endtask

  task automatic test_random();
    int dkind = 0, r;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) iREN = ~iREN;
      if ($urandom_range(0, 6) == 0) dkind = $urandom_range(0, 2);
      dREN = (dkind == 1); dWEN = (dkind == 2);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      r = $urandom_range(0, 99);
      ramstate = (r < 15) ? FREE_DS : (r < 55) ? BUSY_DS : (r < 97) ? ACCESS_DS : ERROR_DS;
      @(negedge CLK);
      model_eval();
      checks++; if (iwait !== e_iwait || dwait !== e_dwait) begin errors++; $display("FAIL rnd_wait: cycle %0d i/d got %b%b expected %b%b", c, iwait, dwait, e_iwait, e_dwait); end
      checks++; if (ramREN !== e_ramREN || ramWEN !== e_ramWEN) begin errors++; $display("FAIL rnd_ctl: cycle %0d REN/WEN got %b%b expected %b%b", c, ramREN, ramWEN, e_ramREN, e_ramWEN); end
      checks++; if (mem_err !== m_err) begin errors++; $display("FAIL rnd_err: cycle %0d mem_err got %b expected %b", c, mem_err, m_err); end
      if (e_ramREN || e_ramWEN) begin
        checks++; if (ramaddr !== e_ramaddr) begin errors++; $display("FAIL rnd_addr: cycle %0d got %h expected %h", c, ramaddr, e_ramaddr); end
      end
      if (e_ramWEN) begin
        checks++; if (ramstore !== e_ramstore) begin errors++; $display("FAIL rnd_store: cycle %0d got %h expected %h", c, ramstore, e_ramstore); end
      end
      if (!e_iwait) begin
        checks++; if (iload !== e_iload) begin errors++; $display("FAIL rnd_iload: cycle %0d got %h expected %h", c, iload, e_iload); end
      end
      if (!e_dwait) begin
        checks++; if (dload !== e_dload) begin errors++; $display("FAIL rnd_dload: cycle %0d got %h expected %h", c, dload, e_dload); end
      end
      tick();
    end
  endtask

  initial begin
    iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    ramstate = FREE_DS;
    model_clear();
    test_reset();
    test_lone_fetch();
    test_contention();
    test_simultaneous();
    test_timeout_error();
    test_withdrawal();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
